// File: rtl/fetch_queue.sv
// fetch_queue: fetch PC, single-outstanding ibus requester and {pc,instr} queue.
// Optional same-cycle bypass when FETCH_QUEUE_BYPASS_EN is defined.
package fetch_queue_pkg;
  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;
endpackage

module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic                         clk,
  input  logic                         reset,
  output ibus_req_t                    ireq,
  input  ibus_resp_t                   iresp,
  input  logic                         redirect_valid,
  input  logic [63:0]                  redirect_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [63:0]                  out_pc,
  output logic [31:0]                  out_instr,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_e;

  state_e         state_q, state_d;
  logic [63:0]    pc_f_q, pc_f_d;
  logic [63:0]    infl_q, infl_d;
  logic [PW-1:0]  rd_q, rd_d;
  logic [PW-1:0]  wr_q, wr_d;
  logic [CW-1:0]  count_q, count_d;

  logic [63:0]    pc_mem_q  [DEPTH];
  logic [31:0]    ins_mem_q [DEPTH];

  logic take, push, pop, bypass;
  logic unused_ok;

  assign unused_ok = ^{iresp.addr_ok, redirect_pc[1:0]};

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = (state_q == REQ) && iresp.data_ok &&
                  !redirect_valid && (count_q == '0);
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    take = (state_q == REQ) && iresp.data_ok && !redirect_valid;
    // a bypassed word taken by decode never lands in storage
    push = take && !(bypass && out_ready);
    pop  = (count_q != '0) && out_ready && !redirect_valid;

    rd_d    = rd_q + PW'(pop);
    wr_d    = wr_q + PW'(push);
    count_d = count_q + CW'(push) - CW'(pop);
    if (redirect_valid) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end

    pc_f_d = pc_f_q;
    if (redirect_valid)
      pc_f_d = {redirect_pc[63:2], 2'b00};
    else if (take)
      pc_f_d = pc_f_q + 64'd4;

    infl_d = (state_q == REQ) ? pc_f_q : infl_q;

    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (redirect_valid || count_q < FULL)
          state_d = REQ;
      end
      REQ: begin
        if (redirect_valid)
          state_d = iresp.data_ok ? REQ : DRAIN;
        else if (iresp.data_ok)
          state_d = (count_d < FULL) ? REQ : IDLE;
      end
      DRAIN: begin
        if (iresp.data_ok)
          state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_f_q  <= RESET_PC;
      infl_q  <= RESET_PC;
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_f_q  <= pc_f_d;
      infl_q  <= infl_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_q]  <= pc_f_q;
      ins_mem_q[wr_q] <= iresp.data;
    end
  end

  always_comb begin
    ireq.valid = (state_q != IDLE);
    ireq.addr  = (state_q == DRAIN) ? infl_q : pc_f_q;
    out_valid  = (count_q != '0) || bypass;
    out_pc     = bypass ? pc_f_q : pc_mem_q[rd_q];
    out_instr  = bypass ? iresp.data : ins_mem_q[rd_q];
    count      = count_q;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed phases plus random traffic against a queue-based
// reference of the fetch front end.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam logic [63:0] RPC = 64'h8000_0000;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        reset;
  ibus_req_t   ireq;
  ibus_resp_t  iresp;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic [2:0]  count;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset), .ireq(ireq), .iresp(iresp),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        q[$];
  logic [63:0] m_pc;
  logic [63:0] m_addr;
  bit          m_req;
  bit          m_drop;
  int          wcnt;
  int          lat;
  bit          rand_lat;
  bit          data_ovr;
  int          total;
  int          bad;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1234_5677;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pc   = RPC;
    m_addr = RPC;
    m_req  = 1'b0;
    m_drop = 1'b0;
    wcnt   = 0;
  endtask

  task automatic do_reset();
    reset          = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    iresp          = '0;
    #1;
    chk("rst_ivalid", ireq.valid, 0);
    chk("rst_count", count, 0);
    chk("rst_ovalid", out_valid, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  // one clock: drive, check against the reference, advance the reference
  task automatic cycle(input bit rdy, input bit redir, input logic [63:0] rpc);
    bit          dok, byp, nreq, ndrop;
    logic [31:0] dat;
    int          occ;
    ent_t        e;
    dok = m_req && (wcnt >= lat);
    dat = dok ? (data_ovr ? 32'h0000_0013 : mem_word(m_addr)) : $urandom;
    out_ready      = rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    iresp.addr_ok  = m_req;
    iresp.data_ok  = dok;
    iresp.data     = dat;
    #1;
    occ = q.size();
    byp = BYP && m_req && !m_drop && dok && !redir && occ == 0;
    chk("ireq_valid", ireq.valid, m_req);
    if (m_req) chk("ireq_addr", ireq.addr, m_addr);
    chk("count", count, occ);
    chk("out_valid", out_valid, occ > 0 || byp);
    if (byp) begin
      chk("byp_pc", out_pc, m_addr);
      chk("byp_instr", out_instr, dat);
    end else if (occ > 0) begin
      chk("out_pc", out_pc, q[0].pc);
      chk("out_instr", out_instr, q[0].ins);
    end
    if (redir) q.delete();
    else begin
      if (occ > 0 && rdy) void'(q.pop_front());
      if (m_req && !m_drop && dok && !(byp && rdy)) begin
        e.pc  = m_addr;
        e.ins = dat;
        q.push_back(e);
      end
    end
    nreq  = m_req;
    ndrop = m_drop;
    if (!m_req) begin
      nreq  = redir || occ < DEPTH;
      ndrop = 1'b0;
    end else if (m_drop) begin
      if (dok) ndrop = 1'b0;
    end else if (redir) begin
      ndrop = !dok;
    end else if (dok) begin
      nreq = q.size() < DEPTH;
    end
    if (redir) m_pc = {rpc[63:2], 2'b00};
    else if (m_req && !m_drop && dok) m_pc = m_pc + 64'd4;
    if (!ndrop) m_addr = m_pc;
    if (m_req) begin
      if (dok) begin
        wcnt = 0;
        if (rand_lat) lat = $urandom_range(0, 3);
      end else wcnt++;
    end
    m_req  = nreq;
    m_drop = ndrop;
    @(negedge clk);
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    lat      = 0;
    rand_lat = 1'b0;
    data_ovr = 1'b0;
    reset    = 1'b0;
    iresp    = '0;
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    model_reset();
    @(negedge clk);

    // streaming with zero-wait memory
    do_reset();
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, 1'b0, '0);
      chk("cnt_le1", count <= 3'd1, 1);
    end

    // fill with decode stalled, then release
    do_reset();
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, '0);
    chk("full_cnt", count, 4);
    chk("full_ivalid", ireq.valid, 0);
    chk("full_head", out_pc, 64'h8000_0000);
    cycle(1'b1, 1'b0, '0);
    cycle(1'b0, 1'b0, '0);
    chk("resume_valid", ireq.valid, 1);
    chk("resume_addr", ireq.addr, 64'h8000_0010);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, '0);

    // redirect while idle with three entries
    do_reset();
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, '0);
    cycle(1'b1, 1'b0, '0);
    chk("pre_redir_cnt", count, 3);
    chk("pre_redir_ivalid", ireq.valid, 0);
    cycle(1'b0, 1'b1, 64'h8000_0102);
    chk("redir_cnt", count, 0);
    chk("redir_ovalid", out_valid, 0);
    chk("redir_ivalid", ireq.valid, 1);
    chk("redir_addr", ireq.addr, 64'h8000_0100);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, '0);

    // redirect with a slow request in flight
    do_reset();
    lat = 3;
    for (int i = 0; i < 40; i++) begin
      if (m_req && !m_drop && m_addr == 64'h8000_0008 && wcnt == 0) break;
      cycle(1'b1, 1'b0, '0);
    end
    chk("req8_issue", ireq.addr, 64'h8000_0008);
    cycle(1'b1, 1'b0, '0);
    cycle(1'b1, 1'b1, 64'h8000_0200);
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, 1'b0, '0);
      chk("no_stale", out_valid && out_pc == 64'h8000_0008, 0);
    end
    lat = 0;

    // redirect coincident with data_ok on the last free slot
    do_reset();
    for (int i = 0; i < 10; i++) begin
      if (m_req && q.size() == 3) break;
      cycle(1'b0, 1'b0, '0);
    end
    chk("last_slot_cnt", count, 3);
    chk("last_slot_ivalid", ireq.valid, 1);
    cycle(1'b1, 1'b1, 64'h8000_0300);
    chk("coinc_cnt", count, 0);
    chk("coinc_ovalid", out_valid, 0);
    chk("coinc_addr", ireq.addr, 64'h8000_0300);

`ifdef FETCH_QUEUE_BYPASS_EN
    do_reset();
    data_ovr = 1'b1;
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, '0);
    data_ovr = 1'b0;
`endif

    // random traffic
    do_reset();
    rand_lat = 1'b1;
    lat = $urandom_range(0, 3);
    for (int i = 0; i < 500; i++)
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
            {32'h0, $urandom});
    rand_lat = 1'b0;
    lat = 0;

    // asynchronous reset while a request is pending
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, '0);
    #2;
    reset = 1'b0;
    #1;
    chk("async_ivalid", ireq.valid, 0);
    chk("async_cnt", count, 0);
    chk("async_ovalid", out_valid, 0);
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
